// File: rtl/mouse_pkg.sv
// Shared types and constants for the PS/2 mouse tracker: packet FSM states,
// status-byte bit positions, default screen geometry and axis helpers.
package mouse_pkg;

  typedef enum logic [1:0] {
    WAIT_B0,
    WAIT_B1,
    WAIT_B2,
    APPLY
  } state_e;

  // Bit positions inside the PS/2 status byte
  localparam int LEFT    = 0;
  localparam int RIGHT   = 1;
  localparam int ALWAYS1 = 3;
  localparam int XSIGN   = 4;
  localparam int YSIGN   = 5;
  localparam int XOVF    = 6;
  localparam int YOVF    = 7;

  // Default screen bounds, shared with the pixel generator
  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;
  localparam int INIT_X_DEF   = 320;
  localparam int INIT_Y_DEF   = 240;
  localparam int TIMEOUT_DEF  = 50000;

  // Signed 12-bit movement for one axis; an overflowed axis contributes nothing
  function automatic logic signed [11:0] axisDelta(input logic       sign,
                                                   input logic [7:0] mag,
                                                   input logic       ovf);
    logic signed [11:0] d;
    d = {{4{sign}}, mag};
    if (ovf) begin
      d = '0;
    end
    return d;
  endfunction

  // Saturate a signed intermediate into 0..maxV
  function automatic logic [9:0] clampAxis(input logic signed [11:0] v,
                                           input logic signed [11:0] maxV);
    logic [9:0] r;
    if (v < 12'sd0) begin
      r = '0;
    end else if (v > maxV) begin
      r = maxV[9:0];
    end else begin
      r = v[9:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_rx_byte.sv
// PS/2 byte receiver: synchronises the line pair, detects ps2_clk falling
// edges, shifts in 11-bit frames, validates start/parity/stop and drops a
// stalled partial frame after a timeout.
module ps2_rx_byte
  import mouse_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] byte_o,
  output logic       byte_strobe_o,
  output logic       err_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    clkSync_q;
  logic [1:0]    dataSync_q;
  logic          clkPrev_q;
  logic [10:0]   shift_q, shift_d;
  logic [3:0]    bitCnt_q, bitCnt_d;
  logic [TW-1:0] toCnt_q, toCnt_d;
  logic [7:0]    byte_q, byte_d;
  logic          strobe_q, strobe_d;
  logic          err_q, err_d;
  logic          fallEdge;
  logic [10:0]   frame;

  assign fallEdge = clkPrev_q & ~clkSync_q[1];
  assign frame    = {dataSync_q[1], shift_q[10:1]};

  // Two-flop synchronisers plus previous-value flop; lines idle high
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clkSync_q  <= 2'b11;
      dataSync_q <= 2'b11;
      clkPrev_q  <= 1'b1;
    end else begin
      clkSync_q  <= {clkSync_q[0], ps2_clk_i};
      dataSync_q <= {dataSync_q[0], ps2_data_i};
      clkPrev_q  <= clkSync_q[1];
    end
  end

  // Shift bits on each falling edge, judge the frame on the 11th, watch for stalls
  always_comb begin
    shift_d  = shift_q;
    bitCnt_d = bitCnt_q;
    toCnt_d  = toCnt_q;
    byte_d   = byte_q;
    strobe_d = 1'b0;
    err_d    = 1'b0;
    if (fallEdge) begin
      shift_d = frame;
      toCnt_d = '0;
      if (bitCnt_q == 4'd10) begin
        bitCnt_d = '0;
        if (!frame[0] && frame[10] && (^frame[9:1])) begin
          byte_d   = frame[8:1];
          strobe_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end else begin
        bitCnt_d = bitCnt_q + 4'd1;
      end
    end else if (bitCnt_q != 4'd0) begin
      if (toCnt_q == TO_LAST) begin
        bitCnt_d = '0;
        toCnt_d  = '0;
        err_d    = 1'b1;
      end else begin
        toCnt_d = toCnt_q + 1'b1;
      end
    end else begin
      toCnt_d = '0;
    end
  end

  // Receiver state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shift_q  <= '0;
      bitCnt_q <= '0;
      toCnt_q  <= '0;
      byte_q   <= '0;
      strobe_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      bitCnt_q <= bitCnt_d;
      toCnt_q  <= toCnt_d;
      byte_q   <= byte_d;
      strobe_q <= strobe_d;
      err_q    <= err_d;
    end
  end

  assign byte_o        = byte_q;
  assign byte_strobe_o = strobe_q;
  assign err_o         = err_q;

endmodule

// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse tracker: gathers 3-byte movement packets, integrates motion into
// a screen-clamped cursor position and reports buttons and left-click pulses.
module ps2_mouse_tracker
  import mouse_pkg::*;
#(
  parameter int SCREEN_W       = SCREEN_W_DEF,
  parameter int SCREEN_H       = SCREEN_H_DEF,
  parameter int INIT_X         = INIT_X_DEF,
  parameter int INIT_Y         = INIT_Y_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [9:0] mousex,
  output logic [9:0] mousey,
  output logic       btn_left,
  output logic       btn_right,
  output logic       click,
  output logic       packet_valid,
  output logic       frame_err
);

  localparam logic signed [11:0] MAX_X = 12'(SCREEN_W - 1);
  localparam logic signed [11:0] MAX_Y = 12'(SCREEN_H - 1);
  localparam logic [9:0]         X0    = 10'(INIT_X);
  localparam logic [9:0]         Y0    = 10'(INIT_Y);

  logic [7:0] rxByte;
  logic       rxStrobe;
  logic       rxErr;

  state_e     state_q, state_d;
  logic [7:0] status_q, status_d;
  logic [7:0] xByte_q, xByte_d;
  logic [7:0] yByte_q, yByte_d;
  logic [9:0] mousex_q, mousex_d;
  logic [9:0] mousey_q, mousey_d;
  logic       btnLeft_q, btnLeft_d;
  logic       btnRight_q, btnRight_d;
  logic       click_q, click_d;
  logic       valid_q, valid_d;

  logic signed [11:0] nx;
  logic signed [11:0] ny;

  ps2_rx_byte #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk          (clk),
    .reset_n      (reset_n),
    .ps2_clk_i    (ps2_clk),
    .ps2_data_i   (ps2_data),
    .byte_o       (rxByte),
    .byte_strobe_o(rxStrobe),
    .err_o        (rxErr)
  );

  // Packet sequencing and cursor/button update computed from latched bytes
  always_comb begin
    state_d    = state_q;
    status_d   = status_q;
    xByte_d    = xByte_q;
    yByte_d    = yByte_q;
    mousex_d   = mousex_q;
    mousey_d   = mousey_q;
    btnLeft_d  = btnLeft_q;
    btnRight_d = btnRight_q;
    click_d    = 1'b0;
    valid_d    = 1'b0;
    nx = $signed({2'b00, mousex_q}) + axisDelta(status_q[XSIGN], xByte_q, status_q[XOVF]);
    ny = $signed({2'b00, mousey_q}) - axisDelta(status_q[YSIGN], yByte_q, status_q[YOVF]);
    case (state_q)
      WAIT_B0: begin
        if (rxStrobe && rxByte[ALWAYS1]) begin
          status_d = rxByte;
          state_d  = WAIT_B1;
        end
      end
      WAIT_B1: begin
        if (rxErr) begin
          state_d = WAIT_B0;
        end else if (rxStrobe) begin
          xByte_d = rxByte;
          state_d = WAIT_B2;
        end
      end
      WAIT_B2: begin
        if (rxErr) begin
          state_d = WAIT_B0;
        end else if (rxStrobe) begin
          yByte_d = rxByte;
          state_d = APPLY;
        end
      end
      APPLY: begin
        state_d    = WAIT_B0;
        mousex_d   = clampAxis(nx, MAX_X);
        mousey_d   = clampAxis(ny, MAX_Y);
        btnLeft_d  = status_q[LEFT];
        btnRight_d = status_q[RIGHT];
        click_d    = status_q[LEFT] & ~btnLeft_q;
        valid_d    = 1'b1;
      end
      default: begin
        state_d = WAIT_B0;
      end
    endcase
  end

  // Packet FSM, latched bytes and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= WAIT_B0;
      status_q   <= '0;
      xByte_q    <= '0;
      yByte_q    <= '0;
      mousex_q   <= X0;
      mousey_q   <= Y0;
      btnLeft_q  <= 1'b0;
      btnRight_q <= 1'b0;
      click_q    <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      status_q   <= status_d;
      xByte_q    <= xByte_d;
      yByte_q    <= yByte_d;
      mousex_q   <= mousex_d;
      mousey_q   <= mousey_d;
      btnLeft_q  <= btnLeft_d;
      btnRight_q <= btnRight_d;
      click_q    <= click_d;
      valid_q    <= valid_d;
    end
  end

  assign mousex       = mousex_q;
  assign mousey       = mousey_q;
  assign btn_left     = btnLeft_q;
  assign btn_right    = btnRight_q;
  assign click        = click_q;
  assign packet_valid = valid_q;
  assign frame_err    = rxErr;

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Self-checking bench for ps2_mouse_tracker: directed PS/2 packets, a
// packet-level behavioural model and a per-cycle output compare process.
module tb_ps2_mouse_tracker;

  localparam int H = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2Clk = 1'b1;
  logic       ps2Data = 1'b1;
  logic [9:0] mousex, mousey;
  logic       btn_left, btn_right, click, packet_valid, frame_err;

  int assertions = 0;
  int failures = 0;

  typedef struct {
    int x;
    int y;
    bit l;
    bit r;
    bit c;
  } pkt_t;

  pkt_t expQ[$];

  int mX, mY, phase, expErr;
  bit mL, mR;
  logic [7:0] mSt, mXb;
  int heldX, heldY;
  bit heldL, heldR;
  bit checkEn = 1'b0;
  int errSeen = 0, pvSeen = 0, clickSeen = 0;

  ps2_mouse_tracker dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ps2_clk     (ps2Clk),
    .ps2_data    (ps2Data),
    .mousex      (mousex),
    .mousey      (mousey),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .click       (click),
    .packet_valid(packet_valid),
    .frame_err   (frame_err)
  );

  // 100 MHz-style free running system clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clampInt(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  // Packet-level model: fed each good byte before it goes on the wire
  task automatic modelByte(input logic [7:0] b);
    int dx, dy;
    pkt_t p;
    case (phase)
      0: if (b[3]) begin mSt = b; phase = 1; end
      1: begin mXb = b; phase = 2; end
      default: begin
        dx = mSt[4] ? int'(mXb) - 256 : int'(mXb);
        dy = mSt[5] ? int'(b) - 256 : int'(b);
        if (mSt[6]) dx = 0;
        if (mSt[7]) dy = 0;
        p.x = clampInt(mX + dx, 639);
        p.y = clampInt(mY - dy, 479);
        p.l = mSt[0];
        p.r = mSt[1];
        p.c = mSt[0] && !mL;
        mX = p.x; mY = p.y; mL = p.l; mR = p.r;
        expQ.push_back(p);
        phase = 0;
      end
    endcase
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive the first nBits of an 11-bit PS/2 frame; badPar flips the parity bit
  task automatic sendFrame(input logic [7:0] b, input bit badPar, input int nBits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ badPar, b, 1'b0};
    for (int i = 0; i < nBits; i++) begin
      ps2Data = f[i];
      cycles(H);
      ps2Clk = 1'b0;
      cycles(H);
      ps2Clk = 1'b1;
    end
    cycles(H);
    ps2Data = 1'b1;
  endtask

  task automatic applyStimulus(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    modelByte(b0); sendFrame(b0, 1'b0, 11);
    modelByte(b1); sendFrame(b1, 1'b0, 11);
    modelByte(b2); sendFrame(b2, 1'b0, 11);
    cycles(12);
  endtask

  task automatic doReset();
    checkEn = 1'b0;
    reset_n = 1'b0;
    ps2Clk = 1'b1;
    ps2Data = 1'b1;
    cycles(4);
    expQ.delete();
    mX = 320; mY = 240; mL = 0; mR = 0; phase = 0;
    heldX = 320; heldY = 240; heldL = 0; heldR = 0;
    reset_n = 1'b1;
    checkEn = 1'b1;
  endtask

  // Compare process: packet outputs against the model queue, held values otherwise
  always @(negedge clk) begin
    if (checkEn) begin
      if (frame_err) errSeen++;
      if (packet_valid) begin
        pvSeen++;
        if (click) clickSeen++;
        if (expQ.size() == 0) begin
          checkOutput("unexpected_packet", 32'd1, 32'd0);
        end else begin
          pkt_t e;
          e = expQ.pop_front();
          checkOutput("pkt_x", {22'd0, mousex}, e.x);
          checkOutput("pkt_y", {22'd0, mousey}, e.y);
          checkOutput("pkt_btn", {29'd0, btn_left, btn_right, click}, {29'd0, e.l, e.r, e.c});
          heldX = e.x; heldY = e.y; heldL = e.l; heldR = e.r;
        end
      end else begin
        checkOutput("hold", {9'd0, mousex, mousey, btn_left, btn_right, click},
                    {9'd0, 10'(heldX), 10'(heldY), heldL, heldR, 1'b0});
      end
    end
  end

  initial begin
    expErr = 0;
    doReset();
    checkOutput("reset_x", {22'd0, mousex}, 32'd320);
    checkOutput("reset_y", {22'd0, mousey}, 32'd240);
    checkOutput("reset_pulses", {28'd0, btn_left, btn_right, click, packet_valid}, 32'd0);

    applyStimulus(8'h08, 8'h0A, 8'h05);
    checkOutput("lit_first_x", {22'd0, mousex}, 32'd330);
    checkOutput("lit_first_y", {22'd0, mousey}, 32'd235);
    checkOutput("lit_first_pv", pvSeen, 32'd1);
    checkOutput("lit_first_click", clickSeen, 32'd0);

    applyStimulus(8'h18, 8'h00, 8'h00);
    applyStimulus(8'h18, 8'h00, 8'h00);
    checkOutput("lit_clamp_x0", {22'd0, mousex}, 32'd0);

    for (int i = 0; i < 6; i++) applyStimulus(8'h08, 8'h7F, 8'h00);
    checkOutput("lit_clamp_xmax", {22'd0, mousex}, 32'd639);

    for (int i = 0; i < 2; i++) applyStimulus(8'h08, 8'h00, 8'h7F);
    checkOutput("lit_clamp_y0", {22'd0, mousey}, 32'd0);

    applyStimulus(8'h09, 8'h00, 8'h00);
    checkOutput("lit_click1", clickSeen, 32'd1);
    checkOutput("lit_left", {31'd0, btn_left}, 32'd1);
    applyStimulus(8'h09, 8'h00, 8'h00);
    checkOutput("lit_click_hold", clickSeen, 32'd1);
    applyStimulus(8'h08, 8'h00, 8'h00);
    applyStimulus(8'h09, 8'h00, 8'h00);
    checkOutput("lit_click2", clickSeen, 32'd2);
    applyStimulus(8'h0A, 8'h00, 8'h00);
    checkOutput("lit_right", {30'd0, btn_left, btn_right}, 32'd1);

    modelByte(8'h08); sendFrame(8'h08, 1'b0, 11);
    phase = 0; expErr++;
    sendFrame(8'h10, 1'b1, 11);
    cycles(12);
    checkOutput("lit_parity_err", errSeen, expErr);
    checkOutput("lit_parity_x", {22'd0, mousex}, 32'd639);
    applyStimulus(8'h18, 8'hF6, 8'h00);
    checkOutput("lit_after_err_x", {22'd0, mousex}, 32'd629);

    doReset();
    modelByte(8'h05); sendFrame(8'h05, 1'b0, 11);
    applyStimulus(8'h08, 8'h02, 8'h00);
    checkOutput("lit_misalign_x", {22'd0, mousex}, 32'd322);

    sendFrame(8'h08, 1'b0, 6);
    expErr++;
    cycles(50020);
    checkOutput("lit_timeout_err", errSeen, expErr);
    applyStimulus(8'h08, 8'h03, 8'h01);
    checkOutput("lit_timeout_x", {22'd0, mousex}, 32'd325);
    checkOutput("lit_timeout_y", {22'd0, mousey}, 32'd239);
    applyStimulus(8'hC8, 8'h50, 8'h50);
    checkOutput("lit_ovf_xy", {12'd0, mousex, mousey}, {12'd0, 10'd325, 10'd239});

    sendFrame(8'h09, 1'b0, 5);
    doReset();
    cycles(2);
    checkOutput("lit_midreset", {12'd0, mousex, mousey}, {12'd0, 10'd320, 10'd240});
    applyStimulus(8'h08, 8'h01, 8'h00);
    checkOutput("lit_postreset_x", {22'd0, mousex}, 32'd321);

    cycles(20);
    checkOutput("queue_empty", expQ.size(), 32'd0);
    checkOutput("err_total", errSeen, expErr);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
